// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with 2-bit direction counters
//
// Purpose:
//   IF-stage next-PC predictor. A fetch PC is looked up combinationally in a
//   direct-mapped table. The table is trained by branch/JAL resolution from EX.
//   The block also flags mispredicts and supplies the recovery PC.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         synchronous active-low reset
//   pc_f_i         fetch PC to look up
//   hit_o          valid entry with matching tag for pc_f_i
//   pred_taken_o   predicted taken for pc_f_i
//   pred_pc_o      predicted next fetch PC
//   opcode_x_i     EX-stage opcode (branch 1100011, JAL 1101111 train the table)
//   pc_x_i         EX-stage instruction PC
//   taken_x_i      resolved direction
//   target_x_i     resolved target
//   pred_taken_x_i prediction that travelled with the instruction
//   pred_pc_x_i    predicted next PC that travelled with the instruction
//   mispredict_o   resolution disagrees with the prediction
//   restore_pc_o   correct next PC when mispredict_o=1
module branch_target_buffer #(
  parameter  int ENTRIES = 32,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_f_i,
  output logic        hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_pc_o,
  input  logic [6:0]  opcode_x_i,
  input  logic [31:0] pc_x_i,
  input  logic        taken_x_i,
  input  logic [31:0] target_x_i,
  input  logic        pred_taken_x_i,
  input  logic [31:0] pred_pc_x_i,
  output logic        mispredict_o,
  output logic [31:0] restore_pc_o
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic [IDX_W-1:0] w_x_idx;
  logic [TAG_W-1:0] w_x_tag;
  logic             w_is_branch;
  logic             w_is_jal;
  logic             w_upd;
  logic             w_x_hit;
  logic             w_hit;
  logic             w_pred_taken;
  logic             w_unused;

  // Low PC bits are always zero for aligned instructions and carry no information.
  assign w_unused = ^{pc_f_i[1:0], pc_x_i[1:0]};

  assign w_f_idx = pc_f_i[IDX_W+1:2];
  assign w_f_tag = pc_f_i[31:IDX_W+2];
  assign w_x_idx = pc_x_i[IDX_W+1:2];
  assign w_x_tag = pc_x_i[31:IDX_W+2];

  assign w_is_branch = (opcode_x_i == OP_BRANCH);
  assign w_is_jal    = (opcode_x_i == OP_JAL);
  assign w_upd       = w_is_branch || w_is_jal;

  // Lookup reads the registered table, so a same-cycle update is seen one cycle later.
  assign w_hit        = rst_ni && r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_pred_taken = w_hit && r_ctr[w_f_idx][1];

  assign hit_o        = w_hit;
  assign pred_taken_o = w_pred_taken;
  assign pred_pc_o    = w_pred_taken ? r_target[w_f_idx] : pc_f_i + 32'd4;

  assign w_x_hit = r_valid[w_x_idx] && (r_tag[w_x_idx] == w_x_tag);

  always_comb begin
    mispredict_o = 1'b0;
    restore_pc_o = 32'd0;
    if (rst_ni) begin
      restore_pc_o = taken_x_i ? target_x_i : pc_x_i + 32'd4;
      if (w_upd) begin
        mispredict_o = (taken_x_i != pred_taken_x_i) ||
                       (taken_x_i && (target_x_i != pred_pc_x_i));
      end
    end
  end

  // Tag and target are only meaningful under valid, so only valid/ctr are reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (w_upd) begin
      if (w_x_hit) begin
        if (taken_x_i) begin
          if (r_ctr[w_x_idx] != 2'b11) r_ctr[w_x_idx] <= r_ctr[w_x_idx] + 2'd1;
          r_target[w_x_idx] <= target_x_i;
        end else if (r_ctr[w_x_idx] != 2'b00) begin
          r_ctr[w_x_idx] <= r_ctr[w_x_idx] - 2'd1;
        end
      end else if (taken_x_i) begin
        // Unconditional jumps start strongly taken; branches weakly taken.
        r_valid[w_x_idx]  <= 1'b1;
        r_tag[w_x_idx]    <= w_x_tag;
        r_target[w_x_idx] <= target_x_i;
        r_ctr[w_x_idx]    <= w_is_jal ? 2'b11 : 2'b10;
      end
    end
  end

endmodule
